// File: rtl/rtc_muxbus_io_ctrl.sv
// Timed master for a multiplexed address/data bus: address, turnaround, strobe, hold.
// Build option: define READY_WAIT_EN to stretch STROBE while bus_ready is low.
//
// state  | meaning
// IDLE   | bus released, waiting for req
// ADDR   | cs_n/ad_n low, address driven on dato
// TURN   | ad_n high; write drives wdata, read releases dato
// STROBE | rd_n or wr_n low
// HOLD   | strobes high, cs_n low, write data still held
module rtc_muxbus_io_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int T_AD   = 2,
  parameter int T_TURN = 1,
  parameter int T_STB  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              cs_n,
  output logic              ad_n,
  output logic              rd_n,
  output logic              wr_n,
  input  logic              bus_ready,
  inout  wire  [DATA_W-1:0] dato
);

  localparam int AD_LEN   = (T_AD   < 1) ? 1 : T_AD;
  localparam int TURN_LEN = (T_TURN < 1) ? 1 : T_TURN;
  localparam int STB_LEN  = (T_STB  < 1) ? 1 : T_STB;
  localparam int MAX_AT   = (AD_LEN > TURN_LEN) ? AD_LEN : TURN_LEN;
  localparam int MAX_LEN  = (MAX_AT > STB_LEN) ? MAX_AT : STB_LEN;
  localparam int CNT_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CNT_W-1:0] AD_LOAD   = CNT_W'(AD_LEN - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_LEN - 1);
  localparam logic [CNT_W-1:0] STB_LOAD  = CNT_W'(STB_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_TURN,
    S_STROBE,
    S_HOLD
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              capture;
  logic              rd_sample;
  logic              ready_ok;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_nxt;

  logic              cs_n_nxt, ad_n_nxt, rd_n_nxt, wr_n_nxt;
  logic              busy_nxt, done_nxt;
  logic [DATA_W-1:0] rdata_nxt;

  logic              bus_oe;
  logic [DATA_W-1:0] bus_out;
  logic [DATA_W-1:0] addr_ext;

`ifdef READY_WAIT_EN
  assign ready_ok = bus_ready;
`else
  logic unused_bus_ready;
  assign unused_bus_ready = bus_ready;
  assign ready_ok = 1'b1;
`endif

  // State register and shared phase down-counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    rd_sample = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          capture   = 1'b1;
          state_nxt = S_ADDR;
          cnt_nxt   = AD_LOAD;
        end
      end
      S_ADDR: begin
        if (cnt == '0) begin
          state_nxt = S_TURN;
          cnt_nxt   = TURN_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_TURN: begin
        if (cnt == '0) begin
          state_nxt = S_STROBE;
          cnt_nxt   = STB_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_STROBE: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if (ready_ok) begin
          // Read data is taken on the edge that closes the last strobe cycle.
          state_nxt = S_HOLD;
          rd_sample = !we_q;
        end
      end
      S_HOLD: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output values are decoded from the next state so the registered pins line up with state.
  always_comb begin
    we_nxt    = capture ? we : we_q;
    cs_n_nxt  = (state_nxt == S_IDLE);
    ad_n_nxt  = (state_nxt != S_ADDR);
    rd_n_nxt  = !((state_nxt == S_STROBE) && !we_nxt);
    wr_n_nxt  = !((state_nxt == S_STROBE) && we_nxt);
    busy_nxt  = (state_nxt != S_IDLE);
    done_nxt  = (state == S_HOLD);
    rdata_nxt = rd_sample ? dato : rdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cs_n    <= 1'b1;
      ad_n    <= 1'b1;
      rd_n    <= 1'b1;
      wr_n    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
    end else begin
      if (capture) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      cs_n  <= cs_n_nxt;
      ad_n  <= ad_n_nxt;
      rd_n  <= rd_n_nxt;
      wr_n  <= wr_n_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      rdata <= rdata_nxt;
    end
  end

  always_comb begin
    addr_ext               = '0;
    addr_ext[ADDR_W-1:0]   = addr_q;
  end

  // Enable comes straight from the state register so reset releases the bus at once.
  assign bus_oe  = (state == S_ADDR) ||
                   (we_q && ((state == S_TURN) || (state == S_STROBE) || (state == S_HOLD)));
  assign bus_out = (state == S_ADDR) ? addr_ext : wdata_q;
  assign dato    = bus_oe ? bus_out : 'z;

endmodule

// File: tb/tb_rtc_muxbus_io_ctrl.sv
// Bench for rtc_muxbus_io_ctrl: default instance plus a 16-bit instance with short phases.
// Expected transfers are queued on request and retired when done pulses.
module tb_rtc_muxbus_io_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       req, we;
  logic [7:0] addr, wdata, rdata;
  logic       busy, done, cs_n, ad_n, rd_n, wr_n, bus_ready;
  wire  [7:0] dato;

  logic        p_req, p_we;
  logic [5:0]  p_addr;
  logic [15:0] p_wdata, p_rdata;
  logic        p_busy, p_done, p_cs_n, p_ad_n, p_rd_n, p_wr_n, p_bus_ready;
  wire  [15:0] p_dato;

  // Device model: drives while rd_n is low, optionally stepping its value each strobe cycle.
  logic [7:0] dev_base;
  logic       dev_inc;
  logic [7:0] strb_cyc = 8'd0;
  logic [7:0] dev_val;
  int         ready_mode;

  always @(posedge clk) strb_cyc <= (!rd_n) ? strb_cyc + 8'd1 : 8'd0;
  assign dev_val   = dev_base + (dev_inc ? strb_cyc : 8'd0);
  assign dato      = (!rd_n) ? dev_val : 8'bz;
  assign bus_ready = (ready_mode == 1) ? (strb_cyc >= 8'd6) : (ready_mode != 2);
  assign p_dato    = (!p_rd_n) ? 16'hBEEF : 16'bz;

  rtc_muxbus_io_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .cs_n(cs_n), .ad_n(ad_n),
    .rd_n(rd_n), .wr_n(wr_n), .bus_ready(bus_ready), .dato(dato)
  );

  rtc_muxbus_io_ctrl #(.DATA_W(16), .ADDR_W(6), .T_AD(0), .T_TURN(1), .T_STB(1)) p_dut (
    .clk(clk), .reset(reset), .req(p_req), .we(p_we), .addr(p_addr), .wdata(p_wdata),
    .rdata(p_rdata), .busy(p_busy), .done(p_done), .cs_n(p_cs_n), .ad_n(p_ad_n),
    .rd_n(p_rd_n), .wr_n(p_wr_n), .bus_ready(p_bus_ready), .dato(p_dato)
  );

  typedef struct {
    logic        we;
    logic [15:0] rdata;
    int          lat;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         viol_cnt = 0;
  logic [7:0] model_rdata;

  // Bus rules that must hold every cycle on both instances.
  always @(negedge clk) begin
    if (reset) begin
      if ((!rd_n && !wr_n) || (!rd_n && dut.bus_oe) || (!ad_n && (!rd_n || !wr_n)) ||
          (!p_rd_n && !p_wr_n) || (!p_rd_n && p_dut.bus_oe) || (!p_ad_n && (!p_rd_n || !p_wr_n)))
        viol_cnt <= viol_cnt + 1;
    end
  end

  // Runs one main-instance transfer whose req is already driven; stops in the done cycle.
  // lat is the edge count from acceptance to the edge at which done is sampled high.
  task automatic run_main(input logic [7:0] a, input logic [7:0] w,
                          output int lat, output int n_ad, output int n_ad_ok,
                          output int n_wr, output int n_wr_ok, output int n_rd,
                          output int n_oe, output int n_busy, output logic [7:0] rd_pre);
    lat = -1; n_ad = 0; n_ad_ok = 0; n_wr = 0; n_wr_ok = 0; n_rd = 0; n_oe = 0; n_busy = 0;
    rd_pre = rdata;
    @(posedge clk); #1;
    req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        lat = i + 1;
        break;
      end
      if (!ad_n) n_ad++;
      if (!ad_n && dut.bus_oe && dato == a) n_ad_ok++;
      if (!wr_n) n_wr++;
      if (!wr_n && dut.bus_oe && dato == w) n_wr_ok++;
      if (!rd_n) begin
        n_rd++;
        rd_pre = rdata;
      end
      if (dut.bus_oe) n_oe++;
      if (busy) n_busy++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({cs_n, ad_n, rd_n, wr_n, busy, done, dut.bus_oe} !== 7'b1111000)
      $display("FAIL reset_ctrl: got %b want 1111000", {cs_n, ad_n, rd_n, wr_n, busy, done, dut.bus_oe});
    else pass_cnt++;
    total_cnt++;
    if (rdata !== 8'h00) $display("FAIL reset_rdata: got %h want 00", rdata);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({busy, done, cs_n} !== 3'b001) $display("FAIL idle_after_reset: got %b want 001", {busy, done, cs_n});
    else pass_cnt++;
  endtask

  task automatic test_write();
    int lat, n_ad, n_ad_ok, n_wr, n_wr_ok, n_rd, n_oe, n_busy;
    logic [7:0] rd_pre;
    we = 1'b1; addr = 8'h21; wdata = 8'h5A; req = 1'b1;
    exp_q.push_back('{we: 1'b1, rdata: {8'h00, model_rdata}, lat: 8});
    run_main(8'h21, 8'h5A, lat, n_ad, n_ad_ok, n_wr, n_wr_ok, n_rd, n_oe, n_busy, rd_pre);
    e = exp_q.pop_front();
    total_cnt++;
    if (lat !== e.lat) $display("FAIL write_latency: got %0d want %0d", lat, e.lat);
    else pass_cnt++;
    total_cnt++;
    if (n_ad !== 2 || n_ad_ok !== 2) $display("FAIL write_addr_phase: got %0d/%0d want 2/2", n_ad, n_ad_ok);
    else pass_cnt++;
    total_cnt++;
    if (n_wr !== 3 || n_wr_ok !== 3) $display("FAIL write_strobe: got %0d/%0d want 3/3", n_wr, n_wr_ok);
    else pass_cnt++;
    total_cnt++;
    if (n_rd !== 0) $display("FAIL write_rd_n: got %0d low cycles want 0", n_rd);
    else pass_cnt++;
    total_cnt++;
    if (n_busy !== 7 || busy !== 1'b0) $display("FAIL write_busy: got %0d,%b want 7,0", n_busy, busy);
    else pass_cnt++;
    total_cnt++;
    if (rdata !== e.rdata[7:0]) $display("FAIL write_rdata_hold: got %h want %h", rdata, e.rdata[7:0]);
    else pass_cnt++;
    total_cnt++;
    if (cs_n !== 1'b1 || dut.bus_oe !== 1'b0) $display("FAIL write_release: got %b%b want 10", cs_n, dut.bus_oe);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (done !== 1'b0) $display("FAIL write_done_pulse: got %b want 0", done);
    else pass_cnt++;
  endtask

  task automatic test_read();
    int lat, n_ad, n_ad_ok, n_wr, n_wr_ok, n_rd, n_oe, n_busy;
    logic [7:0] rd_pre;
    dev_base = 8'hC7; dev_inc = 1'b0;
    we = 1'b0; addr = 8'h23; wdata = 8'hFF; req = 1'b1;
    exp_q.push_back('{we: 1'b0, rdata: 16'h00C7, lat: 8});
    run_main(8'h23, 8'hFF, lat, n_ad, n_ad_ok, n_wr, n_wr_ok, n_rd, n_oe, n_busy, rd_pre);
    e = exp_q.pop_front();
    total_cnt++;
    if (lat !== e.lat) $display("FAIL read_latency: got %0d want %0d", lat, e.lat);
    else pass_cnt++;
    total_cnt++;
    if (rdata !== e.rdata[7:0]) $display("FAIL read_rdata: got %h want %h", rdata, e.rdata[7:0]);
    else pass_cnt++;
    total_cnt++;
    if (rd_pre !== model_rdata) $display("FAIL read_early_sample: got %h want %h", rd_pre, model_rdata);
    else pass_cnt++;
    total_cnt++;
    if (n_oe !== 2 || n_ad_ok !== 2) $display("FAIL read_bus_drive: got %0d/%0d want 2/2", n_oe, n_ad_ok);
    else pass_cnt++;
    total_cnt++;
    if (n_rd !== 3 || n_wr !== 0) $display("FAIL read_strobes: got rd %0d wr %0d want 3 0", n_rd, n_wr);
    else pass_cnt++;
    model_rdata = e.rdata[7:0];
  endtask

  task automatic test_back_to_back();
    int lat, n_ad, n_ad_ok, n_wr, n_wr_ok, n_rd, n_oe, n_busy, n_done;
    logic [7:0] rd_pre;
    we = 1'b1; addr = 8'h30; wdata = 8'h99; req = 1'b1;
    exp_q.push_back('{we: 1'b1, rdata: {8'h00, model_rdata}, lat: 8});
    run_main(8'h30, 8'h99, lat, n_ad, n_ad_ok, n_wr, n_wr_ok, n_rd, n_oe, n_busy, rd_pre);
    e = exp_q.pop_front();
    total_cnt++;
    if (lat !== e.lat || cs_n !== 1'b1) $display("FAIL b2b_first: got lat %0d cs_n %b want %0d 1", lat, cs_n, e.lat);
    else pass_cnt++;
    // Second request issued in the done cycle.
    dev_base = 8'h40; dev_inc = 1'b1;
    we = 1'b0; addr = 8'h31; req = 1'b1;
    exp_q.push_back('{we: 1'b0, rdata: 16'h0042, lat: 8});
    @(posedge clk); #1;
    req = 1'b0;
    total_cnt++;
    if (cs_n !== 1'b0 || done !== 1'b0) $display("FAIL b2b_gap: got cs_n %b done %b want 0 0", cs_n, done);
    else pass_cnt++;
    lat = -1; n_ad_ok = 0; n_rd = 0; n_wr = 0; n_busy = 0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        lat = i + 1;
        break;
      end
      if (!ad_n && dut.bus_oe && dato == 8'h31) n_ad_ok++;
      if (!rd_n) n_rd++;
      if (!wr_n) n_wr++;
      if (busy) n_busy++;
      if (i == 2) begin
        req = 1'b1; we = 1'b1; addr = 8'h77; wdata = 8'h11;
      end
      if (i == 3) req = 1'b0;
      @(posedge clk); #1;
    end
    e = exp_q.pop_front();
    total_cnt++;
    if (lat !== e.lat) $display("FAIL b2b_latency: got %0d want %0d", lat, e.lat);
    else pass_cnt++;
    total_cnt++;
    if (rdata !== e.rdata[7:0]) $display("FAIL b2b_rdata: got %h want %h", rdata, e.rdata[7:0]);
    else pass_cnt++;
    total_cnt++;
    if (n_ad_ok !== 2 || n_rd !== 3 || n_wr !== 0 || n_busy !== 7)
      $display("FAIL b2b_frozen: got ad %0d rd %0d wr %0d busy %0d want 2 3 0 7", n_ad_ok, n_rd, n_wr, n_busy);
    else pass_cnt++;
    model_rdata = e.rdata[7:0];
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    total_cnt++;
    if (n_done !== 0 || busy !== 1'b0) $display("FAIL b2b_ignored_req: got %0d extra done, busy %b want 0 0", n_done, busy);
    else pass_cnt++;
  endtask

  task automatic test_bus_ready();
    int lat, n_ad, n_ad_ok, n_wr, n_wr_ok, n_rd, n_oe, n_busy;
    logic [7:0] rd_pre;
    dev_base = 8'h40; dev_inc = 1'b1;
`ifdef READY_WAIT_EN
    ready_mode = 1;
    exp_q.push_back('{we: 1'b0, rdata: 16'h0046, lat: 12});
`else
    ready_mode = 2;
    exp_q.push_back('{we: 1'b0, rdata: 16'h0042, lat: 8});
`endif
    we = 1'b0; addr = 8'h25; req = 1'b1;
    run_main(8'h25, 8'h00, lat, n_ad, n_ad_ok, n_wr, n_wr_ok, n_rd, n_oe, n_busy, rd_pre);
    e = exp_q.pop_front();
    total_cnt++;
    if (lat !== e.lat) $display("FAIL ready_latency: got %0d want %0d", lat, e.lat);
    else pass_cnt++;
    total_cnt++;
    if (n_rd !== e.lat - 5) $display("FAIL ready_strobe_len: got %0d want %0d", n_rd, e.lat - 5);
    else pass_cnt++;
    total_cnt++;
    if (rdata !== e.rdata[7:0]) $display("FAIL ready_rdata: got %h want %h", rdata, e.rdata[7:0]);
    else pass_cnt++;
    model_rdata = e.rdata[7:0];
    ready_mode = 0;
  endtask

  task automatic test_param();
    int lat, n_ad, n_ad_ok, n_rd;
    p_we = 1'b0; p_addr = 6'h3F; p_req = 1'b1;
    exp_q.push_back('{we: 1'b0, rdata: 16'hBEEF, lat: 5});
    @(posedge clk); #1;
    p_req = 1'b0;
    lat = -1; n_ad = 0; n_ad_ok = 0; n_rd = 0;
    for (int i = 0; i < 100; i++) begin
      if (p_done) begin
        lat = i + 1;
        break;
      end
      if (!p_ad_n) n_ad++;
      if (!p_ad_n && p_dut.bus_oe && p_dato == 16'h003F) n_ad_ok++;
      if (!p_rd_n) n_rd++;
      @(posedge clk); #1;
    end
    e = exp_q.pop_front();
    total_cnt++;
    if (lat !== e.lat) $display("FAIL param_latency: got %0d want %0d", lat, e.lat);
    else pass_cnt++;
    total_cnt++;
    if (n_ad !== 1 || n_ad_ok !== 1) $display("FAIL param_addr: got %0d/%0d want 1/1", n_ad, n_ad_ok);
    else pass_cnt++;
    total_cnt++;
    if (p_rdata !== e.rdata || n_rd !== 1) $display("FAIL param_rdata: got %h rd %0d want %h 1", p_rdata, n_rd, e.rdata);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int n_done;
    dev_base = 8'hC7; dev_inc = 1'b0;
    we = 1'b0; addr = 8'h24; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    total_cnt++;
    if (rd_n !== 1'b0) $display("FAIL abort_in_strobe: got rd_n %b want 0", rd_n);
    else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({cs_n, ad_n, rd_n, wr_n, dut.bus_oe, busy} !== 6'b111100)
      $display("FAIL abort_async: got %b want 111100", {cs_n, ad_n, rd_n, wr_n, dut.bus_oe, busy});
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    model_rdata = 8'h00;
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    total_cnt++;
    if (n_done !== 0 || rdata !== model_rdata)
      $display("FAIL abort_no_done: got done %0d rdata %h want 0 %h", n_done, rdata, model_rdata);
    else pass_cnt++;
  endtask

  task automatic test_protocol();
    total_cnt++;
    if (viol_cnt !== 0) $display("FAIL bus_rules: got %0d violations want 0", viol_cnt);
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    req = 1'b0; we = 1'b0; addr = 8'h00; wdata = 8'h00;
    p_req = 1'b0; p_we = 1'b0; p_addr = 6'h00; p_wdata = 16'h0000; p_bus_ready = 1'b1;
    dev_base = 8'h00; dev_inc = 1'b0; ready_mode = 0; model_rdata = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_bus_ready();
    test_param();
    test_reset_abort();
    test_protocol();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/rtc_muxbus_io_ctrl.md
Name: rtc_muxbus_io_ctrl

Overview:
Parametrised master for a multiplexed address/data bus, as used by the RTC chip and the VGA register bank. It replaces the fixed 8-bit write/read mux with a single request/done handshake. Each transfer runs a timed sequence: address phase, turnaround, strobe, hold. Widths and phase lengths are parameters.

Parameters:
DATA_W, 8, width of shared bus, wdata and rdata.
ADDR_W, 8, address width; must be <= DATA_W; zero-extended onto the bus.
T_AD, 2, cycles of address phase (ad_n low); value 0 is treated as 1.
T_TURN, 1, turnaround cycles between address and strobe; value 0 is treated as 1.
T_STB, 3, cycles rd_n/wr_n held low; value 0 is treated as 1.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req  in  1  transfer request; sampled only while busy=0
we  in  1  1=write, 0=read; captured with req
addr  in  ADDR_W  register address; captured with req
wdata  in  DATA_W  write data; captured with req
rdata  out  DATA_W  last read result
busy  out  1  high from the cycle after acceptance until done
done  out  1  one-cycle pulse at end of every transfer
cs_n  out  1  chip select, active low
ad_n  out  1  address strobe, active low
rd_n  out  1  read strobe, active low
wr_n  out  1  write strobe, active low
bus_ready  in  1  device ready; used only with READY_WAIT_EN
dato  inout  DATA_W  shared address/data bus; high-Z when not driven

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; cs_n=ad_n=rd_n=wr_n=1; dato high-Z; rdata=0; busy=0; done=0; phase counter=0.
- Reset mid-transfer: all strobes deassert and the bus releases immediately, without waiting for a clock edge. The transfer is abandoned and no done pulse is generated.
- FSM states: IDLE, ADDR, TURN, STROBE, HOLD. Each timed phase uses a shared down-counter.
- IDLE: if req=1, capture we/addr/wdata, then go to ADDR with busy=1.
- ADDR (T_AD cycles): cs_n=0, ad_n=0, dato drives zero-extended addr.
- TURN (T_TURN cycles): ad_n=1, cs_n=0.
  - Write: dato drives wdata.
  - Read: dato is high-Z.
- STROBE (T_STB cycles): wr_n=0 (write) or rd_n=0 (read). Write keeps driving wdata.
  - Read: rdata is loaded from dato on the rising edge that ends the final strobe cycle.
- HOLD (1 cycle): strobes=1, cs_n=0. Write keeps driving wdata for hold time; read keeps dato high-Z.
- Return to IDLE: cs_n=1, dato high-Z, done=1 for exactly one cycle, busy=0.
- Latency: done is high T_AD+T_TURN+T_STB+2 rising edges after the edge that sampled req. With defaults this is 8.
- req while busy=1: ignored, with no queueing. Captured inputs are frozen for the whole transfer.
- req=1 in the same cycle as done=1: accepted, so back-to-back transfers are legal. cs_n returns high for exactly one cycle between transfers.
- rdata holds its value across writes and idle time. It changes only at the read sample edge.
- Never: rd_n and wr_n low together; dato driven while rd_n=0; ad_n low while a strobe is low.
- All outputs are registered, except the dato tristate enable, which is decoded from registered state.

Optional Feature:
READY_WAIT_EN
- Defined: once STROBE has run T_STB cycles, STROBE extends while bus_ready=0, sampled each rising edge. Read data is sampled on the first edge where the count is exhausted and bus_ready=1. Latency grows by the number of wait cycles.
- Undefined: bus_ready is ignored; STROBE is exactly T_STB cycles.

Test Plan:
- Write: defaults; req with we=1, addr=0x21, wdata=0x5A -> dato=0x21 with ad_n=0 for 2 cycles; then dato=0x5A with wr_n=0 for 3 cycles; done exactly 8 edges after acceptance; rd_n stays 1.
- Read: we=0, addr=0x23; bench drives 0xC7 on dato while rd_n=0 -> dato high-Z from TURN onward; rdata=0xC7 when done pulses; wr_n stays 1.
- Back-to-back: new req asserted during done -> cs_n high for exactly one cycle; second transfer completes. A req pulse while busy is ignored (done count matches accepted reqs).
- Reset abort: reset=0 in the 2nd STROBE cycle of a read -> strobes and cs_n go to 1 and dato goes high-Z without a clock edge; no done pulse; rdata=0.
- Parametrised: DATA_W=16, ADDR_W=6, T_AD=0, T_STB=1; read addr=0x3F, device returns 0xBEEF -> dato=0x003F in ADDR for 1 cycle; rdata=0xBEEF; latency 5.
- READY_WAIT_EN defined: bus_ready held 0 for 4 cycles after T_STB -> rd_n low for 7 cycles; done at 12 edges; rdata sampled on the bus_ready=1 edge.
